// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int unsigned VALID_BIT = 15;
    localparam int unsigned OVF_BIT   = 14;
    localparam int unsigned ERR_BIT   = 13;
    localparam int unsigned FRAME_LEN = 11;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic odd_weight(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 pins plus a registered falling-edge detector.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic data_clk,
    input  logic data,
    output logic data_sync,
    output logic fall
);

    logic [1:0] clk_meta;
    logic [1:0] data_meta;
    logic       clk_prev;

    // Sync both pins, compare against the previous synced clock, align data with fall
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= {clk_meta[0], data_clk};
            data_meta <= {data_meta[0], data};
            clk_prev  <= clk_meta[1];
            fall      <= clk_prev & ~clk_meta[1];
            data_sync <= data_meta[1];
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks parity, buffers scan codes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_clk,
    input  logic        data,
    input  logic        rd,
    output logic [15:0] io_rdata,
    output logic        not_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic          data_s;
    logic          fall;
    ps2_state_e    state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic          ovf, ferr, ovf_n, ferr_n;
    logic [7:0]    head_n;
    logic          timeout_c, push_c, err_c, shift_c, par_c;
    logic          empty_c, full_c, pop_c, wr_en_c, ovf_set_c, empty_n_c;

    ps2_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .data_clk (data_clk),
        .data     (data),
        .data_sync(data_s),
        .fall     (fall)
    );

    assign timeout_c = (state != IDLE) && !fall && (idle_cnt == CW'(TIMEOUT - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // FSM next state and per-edge control strobes
    always_comb begin
        state_n = state;
        push_c  = 1'b0;
        err_c   = 1'b0;
        shift_c = 1'b0;
        par_c   = 1'b0;
        if (timeout_c) begin
            state_n = IDLE;
            err_c   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) state_n = DATA;
                    else         err_c   = 1'b1;
                end
                DATA: begin
                    shift_c = 1'b1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_c   = 1'b1;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s && odd_weight({parity_bit, shift})) push_c = 1'b1;
                    else                                           err_c  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Frame datapath: bit counter, shift register, parity capture, idle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (state == IDLE)  bit_cnt <= 3'd0;
            else if (shift_c)   bit_cnt <= bit_cnt + 3'd1;
            if (shift_c)        shift <= {data_s, shift[7:1]};
            if (par_c)          parity_bit <= data_s;
            if (state == IDLE || fall) idle_cnt <= '0;
            else                       idle_cnt <= idle_cnt + CW'(1);
        end
    end

    // FIFO control, sticky flags and the next value of the status word
    always_comb begin
        empty_c   = (rd_ptr == wr_ptr);
        full_c    = ((rd_ptr ^ wr_ptr) == {1'b1, {AW{1'b0}}});
        pop_c     = rd && !empty_c;
        wr_en_c   = push_c && (!full_c || pop_c);
        ovf_set_c = push_c && full_c && !pop_c;
        rd_ptr_n  = pop_c   ? rd_ptr + PW'(1) : rd_ptr;
        wr_ptr_n  = wr_en_c ? wr_ptr + PW'(1) : wr_ptr;
        ovf_n     = ovf_set_c | (ovf & ~rd);
        ferr_n    = err_c | (ferr & ~rd);
        empty_n_c = (rd_ptr_n == wr_ptr_n);
        if (empty_n_c)                          head_n = 8'h00;
        else if (wr_en_c && rd_ptr_n == wr_ptr) head_n = shift;
        else                                    head_n = mem[rd_ptr_n[AW-1:0]];
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr[AW-1:0]] <= shift;
    end

    // Pointers, flags and registered status word
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            ferr     <= 1'b0;
            io_rdata <= 16'h0000;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            ovf      <= ovf_n;
            ferr     <= ferr_n;
            io_rdata <= {~empty_n_c, ovf_n, ferr_n, 5'b00000, head_n};
        end
    end

    assign not_empty = io_rdata[VALID_BIT];

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver feeding the calculator's I/O interface: synchronises the external `data_clk`/`data` pair into `clk`, deframes 11-bit PS/2 frames, checks parity and buffers scan codes in a small FIFO. The processor reads buffered codes through a 16-bit memory-mapped word, which the I/O interface returns on `io_mem`. Sits between the FPGA keyboard pins and the I/O interface, upstream of the processor.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `TIMEOUT`, 5000: `clk` cycles without a PS/2 falling edge before a partial frame is abandoned (100 µs at 50 MHz).
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  synchronous, active-high reset.
- `data_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `data`  in  1  raw PS/2 data pin; asynchronous.
- `rd`  in  1  one-cycle pop strobe from the I/O interface (`io_enable` and a load to the keyboard address).
- `io_rdata`  out  16  status/code word: [15] valid (FIFO not empty), [14] overflow, [13] frame_err, [12:8] 0, [7:0] code at FIFO head (0 when empty).
- `not_empty`  out  1  equals `io_rdata[15]`.

## Operation
- Two-flop synchronisers on `data_clk` and `data`. A falling edge is the synchronised clock at 0 with the previous synchronised value at 1. Data is sampled from the synchronised `data` in the edge cycle.
- FSM states and transitions:
  - IDLE: an edge with data 0 → DATA, bit counter 0. An edge with data 1 is a bad start bit; stay in IDLE and set frame_err.
  - DATA: 8 edges, shifted in LSB first, then → PARITY.
  - PARITY: 1 edge; capture the parity bit → STOP.
  - STOP: 1 edge. A frame is good when the stop bit is 1 and the 8 data bits plus parity have odd weight. Good frame: push the code. Bad frame: set frame_err and discard. → IDLE in either case.
- Timeout: in any state other than IDLE, an idle counter runs and resets on every edge. When it reaches `TIMEOUT`, the FSM returns to IDLE, the partial frame is discarded and frame_err is set.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - Full: pointers differ only in the MSB. Empty: pointers are equal.
  - A push while full drops the code and sets overflow.
  - Push and `rd` in the same cycle while full: the pop and the push both succeed; overflow is not set.
  - Push and `rd` in the same cycle while empty: the push succeeds and the `rd` is ignored.
  - `rd` while empty: no effect.
- Sticky flags: overflow and frame_err clear on any `rd`, including `rd` while empty. A set event in the same cycle as `rd` wins, so the flag stays 1.
- `io_rdata` is registered: it reflects FIFO and flag state from the previous cycle's updates.

## Timing
- Reset: FSM to IDLE, both pointers 0, flags 0, synchroniser flops 1 (bus idle), idle counter 0, `io_rdata` 0x0000, `not_empty` 0.
- Reset asserted mid-frame aborts the frame with no push and no flag set. After release, reception resumes at the next start bit.
- Latency:
  - Pin falling edge → edge detected: 3 `clk` cycles (2 synchroniser stages, 1 compare).
  - Stop-bit edge detected → push in that cycle → code and valid on `io_rdata` the following cycle.
- `rd` at cycle n → head advances at n+1 → `io_rdata` shows the next entry (or 0x0000 if empty, flags cleared) at n+1.
- `rd` must be a single-cycle pulse. Holding it high pops one entry per cycle.
- Minimum PS/2 half-period (30 µs) must exceed 4 `clk` periods; this holds for any `clk` ≥ 1 MHz.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Status bit positions: VALID_BIT=15, OVF_BIT=14, ERR_BIT=13.
  - Frame length 11.
- Sub-module `ps2_sync_edge`: synchroniser plus falling-edge detector. Outputs the synchronised data and a one-cycle `fall` pulse.
- FSM, idle counter, FIFO and status register stay in `ps2_keyboard_rx`.

## Test plan
- Good frame, code 0x1C (parity 0, stop 1), PS/2 clock at 10 kHz → exactly one push. `io_rdata` = 0x801C; `rd` → 0x0000.
- Same frame with parity flipped → no push; `io_rdata` = 0x2000. `rd` clears it to 0x0000.
- Five good frames 0x16, 0x1E, 0x26, 0x25, 0x2E with DEPTH=4 and no reads → FIFO holds 0x16..0x25; `io_rdata` = 0xC016. Four `rd` pulses return 0x16, 0x1E, 0x26, 0x25 in order, then 0x0000.
- Start bit plus 4 data bits, then the clock stops for more than `TIMEOUT` cycles → FSM back in IDLE with frame_err set. The next full 0x45 frame is received correctly (0xA045 before `rd`).
- FIFO full, stop-bit edge of a new frame 0x3D coincides with `rd` → no overflow. The FIFO holds the remaining 3 old entries plus 0x3D.
- `rst` pulsed after the 5th data bit → `io_rdata` 0x0000. The next complete 0x1C frame yields 0x801C.
